// File: rtl/seq_det_defs.sv
// Shared definitions for the "1011" serial pattern detector: state encodings,
// state width and the reference pattern.
package seq_det_defs;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_DET  = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

    // Encodings 5..7 are unreachable in normal operation; used for upset recovery.
    function automatic logic state_is_legal(input logic [STATE_W-1:0] s);
        return (s <= 3'd4);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky overflow flag; clr beats inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         ovf_q;
    logic         ovf_d;

    // Next count and overflow: a hit at full scale only raises ovf.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
            ovf_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/seq_det_1011.sv
// Moore detector for the serial pattern "1011" with optional overlap, a
// saturating hit counter and a sticky overflow flag.
module seq_det_1011
    import seq_det_defs::*;
#(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             det,
    output logic             detb,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    state_t state_q;
    state_t state_d;
    logic   det_q;
    logic   detb_q;
    logic   hit_s;

    // Next-state logic; illegal encodings fall back to idle even with en low.
    always_comb begin
        state_d = state_q;
        if (!state_is_legal(state_q)) begin
            state_d = S_IDLE;
        end else if (en) begin
            case (state_q)
                S_IDLE:  state_d = din ? S_1   : S_IDLE;
                S_1:     state_d = din ? S_1   : S_10;
                S_10:    state_d = din ? S_101 : S_IDLE;
                S_101:   state_d = din ? S_DET : S_10;
                S_DET:   state_d = din ? S_1   : (OVERLAP ? S_10 : S_IDLE);
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Only a real entry into S_DET counts; parking there with en low does not.
    assign hit_s = en & (state_d == S_DET);

    // State register with det/detb registered from the same next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            det_q   <= 1'b0;
            detb_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            det_q   <= (state_d == S_DET);
            detb_q  <= (state_d != S_DET);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_s),
        .clr (clr),
        .cnt (count),
        .ovf (ovf)
    );

    assign det     = det_q;
    assign detb    = detb_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_seq_det_1011.sv
// Bench for seq_det_1011: overlap, non-overlap and 2-bit-counter instances
// share one stimulus stream; expectations go through a scoreboard queue.
module tb_seq_det_1011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;

    logic       det_ov, detb_ov, ovf_ov;
    logic [2:0] st_ov;
    logic [7:0] cnt_ov;
    logic       det_nv, detb_nv, ovf_nv;
    logic [2:0] st_nv;
    logic [7:0] cnt_nv;
    logic       det_sa, detb_sa, ovf_sa;
    logic [2:0] st_sa;
    logic [1:0] cnt_sa;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_det_1011 #(.OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
        .det(det_ov), .detb(detb_ov), .state_o(st_ov), .count(cnt_ov), .ovf(ovf_ov));

    seq_det_1011 #(.OVERLAP(1'b0), .CNT_W(8)) dut_nv (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
        .det(det_nv), .detb(detb_nv), .state_o(st_nv), .count(cnt_nv), .ovf(ovf_nv));

    seq_det_1011 #(.OVERLAP(1'b1), .CNT_W(2)) dut_sa (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
        .det(det_sa), .detb(detb_sa), .state_o(st_sa), .count(cnt_sa), .ovf(ovf_sa));

    typedef struct {
        int    dut;
        int    st;
        int    cnt;
        int    ovf;
        string tag;
    } exp_t;

    typedef struct {
        logic rst_before;
        logic din;
        logic en;
        logic clr;
        int   st_ov;
        int   st_nv;
        int   cnt_ov;
        int   cnt_nv;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_entry(input exp_t x);
        int st, cnt, ov, dt, dtb;
        case (x.dut)
            0: begin st = int'(st_ov); cnt = int'(cnt_ov); ov = int'(ovf_ov); dt = int'(det_ov); dtb = int'(detb_ov); end
            1: begin st = int'(st_nv); cnt = int'(cnt_nv); ov = int'(ovf_nv); dt = int'(det_nv); dtb = int'(detb_nv); end
            default: begin st = int'(st_sa); cnt = int'(cnt_sa); ov = int'(ovf_sa); dt = int'(det_sa); dtb = int'(detb_sa); end
        endcase
        chk($sformatf("%s/d%0d state", x.tag, x.dut), st, x.st);
        chk($sformatf("%s/d%0d det", x.tag, x.dut), dt, (x.st == 4) ? 1 : 0);
        chk($sformatf("%s/d%0d detb", x.tag, x.dut), dtb, (x.st == 4) ? 0 : 1);
        chk($sformatf("%s/d%0d count", x.tag, x.dut), cnt, x.cnt);
        chk($sformatf("%s/d%0d ovf", x.tag, x.dut), ov, x.ovf);
    endtask

    // Drive at negedge, clock once, then drain the scoreboard just after posedge.
    task automatic step(input logic d, input logic e, input logic c);
        @(negedge clk);
        din = d;
        en  = e;
        clr = c;
        @(posedge clk);
        #1;
        while (sb.size() > 0) check_entry(sb.pop_front());
    endtask

    // Asynchronous reset: asserted between edges and checked before any posedge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        din = 1'b0;
        en  = 1'b0;
        clr = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check_entry('{d, 0, 0, 0, tag});
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Overlap vs non-overlap on 1,0,1,1,0,1,1
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3, 3, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4, 4, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3, 1, 1, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4, 1, 2, 1});
        // Enable gating, then parking in S_DET with en low
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3, 3, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4, 4, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4, 4, 1, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4, 4, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1, 1});
        // clr on the same edge as the hit
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3, 3, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4, 4, 0, 0});

        #2;
        rst = 1'b0;
        do_reset("por");

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset($sformatf("rst_v%0d", i));
            sb.push_back('{0, vecs[i].st_ov, vecs[i].cnt_ov, 0, $sformatf("v%0d", i)});
            sb.push_back('{1, vecs[i].st_nv, vecs[i].cnt_nv, 0, $sformatf("v%0d", i)});
            step(vecs[i].din, vecs[i].en, vecs[i].clr);
        end

        // Saturation with a 2-bit counter: four separated hits, then clr
        do_reset("rst_sat");
        for (int h = 0; h < 4; h++) begin
            logic [5:0] bits;
            int         sts [6];
            bits = 6'b101100;
            sts  = '{1, 2, 3, 4, 2, 0};
            for (int j = 0; j < 6; j++) begin
                int c;
                c = (j >= 3) ? h + 1 : h;
                if (c > 3) c = 3;
                sb.push_back('{2, sts[j], c, (j >= 3 && h == 3) ? 1 : 0,
                               $sformatf("sat_h%0d_b%0d", h, j)});
                step(bits[5-j], 1'b1, 1'b0);
            end
        end
        sb.push_back('{2, 0, 0, 0, "sat_clr"});
        step(1'b0, 1'b1, 1'b1);

        // Async reset while in S_101 with a nonzero count, then resume
        do_reset("rst_pre");
        begin
            logic [5:0] bits;
            int         sts [6];
            int         cs  [6];
            bits = 6'b101101;
            sts  = '{1, 2, 3, 4, 2, 3};
            cs   = '{0, 0, 0, 1, 1, 1};
            for (int j = 0; j < 6; j++) begin
                sb.push_back('{0, sts[j], cs[j], 0, $sformatf("pre_b%0d", j)});
                step(bits[5-j], 1'b1, 1'b0);
            end
        end
        do_reset("rst_mid");
        begin
            logic [3:0] bits;
            int         sts [4];
            int         cs  [4];
            bits = 4'b1011;
            sts  = '{1, 2, 3, 4};
            cs   = '{0, 0, 0, 1};
            for (int j = 0; j < 4; j++) begin
                sb.push_back('{0, sts[j], cs[j], 0, $sformatf("post_b%0d", j)});
                step(bits[3-j], 1'b1, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
